qea_state_reader: RTL and testbench
===================================

// Module: qea_state_reader
// PURPOSE
//  Host-side readback engine for the QEA state RAM port. After the QEA asserts completion, it sweeps
//  every state word, splits each PE_NUM-wide word into single amplitudes, and streams them out on a
//  valid/ready interface with index and last flags. It mirrors the host write/load path and drives
//  the same ena/wea/addra port, read-only. It sits between the QEA top and the host/result sink.
// PARAMETERS
//  PE_NUM_WIDTH      2   log2(PE_NUM)
//  PE_NUM            4   amplitudes per state word
//  DATA_WIDTH        32  real/imag component width (Q2.30 fixed point)
//  STATE_DATA_WIDTH  64  one amplitude {real,imag} = DATA_WIDTH*2
//  STATE_ADDR_WIDTH  16  state RAM address width
//  MAX_QBIT_WIDTH    6   width of qubit-count input
//  RAM_RD_LATENCY    1   cycles from o_state_ena=1 to valid i_state_dout (>=1)
// PORTS
//  clk            in   1                        clock
//  rst_n          in   1                        synchronous active-low reset
//  i_start        in   1                        one-cycle pulse: begin readback (tie to QEA o_complete edge)
//  i_qbit_num     in   MAX_QBIT_WIDTH           qubit count; sampled only on accepted i_start
//  o_state_ena    out  1                        state RAM enable
//  o_state_wea    out  1                        state RAM write enable; always 0
//  o_state_addra  out  STATE_ADDR_WIDTH         state RAM word address
//  i_state_dout   in   PE_NUM*STATE_DATA_WIDTH  state RAM read data
//  o_amp_valid    out  1                        amplitude beat valid
//  i_amp_ready    in   1                        sink ready
//  o_amp_data     out  STATE_DATA_WIDTH         amplitude {real[63:32], imag[31:0]}
//  o_amp_index    out  STATE_ADDR_WIDTH+PE_NUM_WIDTH  basis-state index of the beat
//  o_amp_last     out  1                        high on the final beat
//  o_busy         out  1                        high from accepted start until o_done
//  o_done         out  1                        one-cycle pulse after last beat is accepted
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): FSM=IDLE. All outputs = 0, counters = 0. Overrides any state, mid-stream included.
//  - FSM: IDLE -> READ -> WAIT -> STREAM -> (READ | FIN) -> IDLE.
//    IDLE: i_start=1 latches n=i_qbit_num and goes to READ. i_start is ignored in every other state.
//    READ: one cycle with o_state_ena=1 and o_state_addra=word counter.
//    WAIT: i_state_dout is registered into the word buffer exactly RAM_RD_LATENCY cycles after the READ cycle.
//    STREAM: o_amp_valid=1 from the cycle after capture. Beats are emitted slot k=0..S-1.
//      Slot k = i_state_dout[(PE_NUM-k)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH], so k=0 is the MSB slot.
//      o_amp_index = word*PE_NUM + k.
//    FIN: o_done=1 for one cycle, o_busy=0, then return to IDLE.
//  - Word count W = 2^(n-PE_NUM_WIDTH) for n>PE_NUM_WIDTH, else W=1.
//  - Slots per word S = PE_NUM for n>=PE_NUM_WIDTH, else S=2^n (n=0 gives 1 beat).
//  - n is clamped to STATE_ADDR_WIDTH+PE_NUM_WIDTH.
//  - Handshake: a beat transfers when o_amp_valid && i_amp_ready.
//    While valid && !ready, o_amp_data, o_amp_index and o_amp_last hold stable. Valid never drops before transfer.
//    Back-to-back beats within a word: one per cycle when ready=1.
//  - After slot S-1 of word w transfers: if w<W-1, go to READ with addr w+1; else go to FIN.
//    o_amp_valid=0 during READ/WAIT, so the word gap is 1+RAM_RD_LATENCY cycles.
//  - o_amp_last = 1 only on index W*S-1.
//  - o_done asserts in the cycle after the last transfer.
//  - Address arithmetic: 2^(n-PE_NUM_WIDTH)-1 computed without overflow at clamp (W up to 2^STATE_ADDR_WIDTH).
//  - o_state_ena is never high outside READ. o_state_wea is constant 0.
// TESTING
//  1. n=8, RAM word0={40000000_00000000,0,0,0}, rest 0, ready=1
//     -> 256 beats; beat0 data=40000000_00000000 idx=0; idx 1..255 data=0; last at idx 255; o_done once.
//  2. n=8, ready toggled pseudo-randomly (50%) -> identical 256-beat sequence, data stable while stalled, no loss or duplication.
//  3. n=2 -> exactly 1 READ (addr 0) and 4 beats idx 0..3, last on idx 3.
//     n=1 -> 2 beats idx 0..1. n=0 -> 1 beat idx 0.
//  4. i_start re-pulsed mid-stream with n=4 -> ignored; run completes with the original n=8 count.
//  5. rst_n=0 for 1 cycle at beat 100 -> next cycle all outputs 0, FSM IDLE;
//     a new i_start restarts at addr 0, idx 0.
//  6. RAM_RD_LATENCY=2 with a RAM model of latency 2 -> correct data on every beat;
//     READ-to-first-valid = 3 cycles per word.

Source files
------------

// File: rtl/qea_state_reader.sv
// Sweeps the QEA state RAM after completion and streams single amplitudes out on a valid/ready port.
// Word gap is 1+RAM_RD_LATENCY cycles; within a word one beat per cycle while the sink is ready.
module qea_state_reader #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RAM_RD_LATENCY   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
  output logic                                   o_state_ena,
  output logic                                   o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
  output logic                                   o_amp_valid,
  input  logic                                   i_amp_ready,
  output logic [STATE_DATA_WIDTH-1:0]            o_amp_data,
  output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_index,
  output logic                                   o_amp_last,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int NMAX   = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int WAIT_W = (RAM_RD_LATENCY > 1) ? $clog2(RAM_RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [STATE_ADDR_WIDTH-1:0]        word_cnt;
  logic [PE_NUM_WIDTH-1:0]            slot_cnt;
  logic [STATE_ADDR_WIDTH-1:0]        word_last;
  logic [PE_NUM_WIDTH-1:0]            slot_last;
  logic [WAIT_W-1:0]                  wait_cnt;
  logic [PE_NUM*STATE_DATA_WIDTH-1:0] word_buf;

  logic [MAX_QBIT_WIDTH-1:0]   n_clamp;
  logic [MAX_QBIT_WIDTH-1:0]   w_shift;
  logic [MAX_QBIT_WIDTH-1:0]   s_shift;
  logic [STATE_ADDR_WIDTH-1:0] word_last_calc;
  logic [PE_NUM_WIDTH-1:0]     slot_last_calc;
  logic [STATE_DATA_WIDTH-1:0] amp_sel;
  logic                        fire;
  logic                        wait_end;
  logic                        slot_end;
  logic                        word_end;

  // Last word/slot as all-ones masks: a shift by the full width yields all ones, so the clamp case cannot overflow.
  always_comb begin
    n_clamp = i_qbit_num;
    if (i_qbit_num > MAX_QBIT_WIDTH'(NMAX)) n_clamp = MAX_QBIT_WIDTH'(NMAX);
    w_shift = '0;
    if (n_clamp > MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) w_shift = n_clamp - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    s_shift = n_clamp;
    if (n_clamp >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) s_shift = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    word_last_calc = ~({STATE_ADDR_WIDTH{1'b1}} << w_shift);
    slot_last_calc = ~({PE_NUM_WIDTH{1'b1}} << s_shift);
  end

  assign fire     = (state == ST_STREAM) && i_amp_ready;
  assign wait_end = (wait_cnt == WAIT_W'(RAM_RD_LATENCY - 1));
  assign slot_end = (slot_cnt == slot_last);
  assign word_end = (word_cnt == word_last);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_start) state_nxt = ST_READ;
      ST_READ:   state_nxt = ST_WAIT;
      ST_WAIT:   if (wait_end) state_nxt = ST_STREAM;
      ST_STREAM: if (fire && slot_end) state_nxt = word_end ? ST_FIN : ST_READ;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      slot_cnt  <= '0;
      word_last <= '0;
      slot_last <= '0;
      wait_cnt  <= '0;
      word_buf  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            word_last <= word_last_calc;
            slot_last <= slot_last_calc;
            word_cnt  <= '0;
            slot_cnt  <= '0;
          end
        end
        ST_READ: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_end) word_buf <= i_state_dout;
        end
        ST_STREAM: begin
          if (fire) begin
            if (slot_end) begin
              slot_cnt <= '0;
              word_cnt <= word_cnt + 1'b1;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot 0 is the most significant amplitude of the word.
  always_comb begin
    amp_sel = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      if (slot_cnt == PE_NUM_WIDTH'(k))
        amp_sel = word_buf[(PE_NUM-k)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH];
    end
  end

  assign o_state_ena   = (state == ST_READ);
  assign o_state_wea   = 1'b0;
  assign o_state_addra = (state == ST_READ) ? word_cnt : '0;
  assign o_amp_valid   = (state == ST_STREAM);
  assign o_amp_data    = o_amp_valid ? amp_sel : '0;
  assign o_amp_index   = o_amp_valid ? {word_cnt, slot_cnt} : '0;
  assign o_amp_last    = o_amp_valid && slot_end && word_end;
  assign o_busy        = (state == ST_READ) || (state == ST_WAIT) || (state == ST_STREAM);
  assign o_done        = (state == ST_FIN);

endmodule

// File: tb/tb_qea_state_reader.sv
// Bench for qea_state_reader: latency-1 and latency-2 instances against RAM models and a beat scoreboard.
module tb_qea_state_reader;

  typedef struct {
    logic [63:0] d;
    logic [17:0] idx;
    logic        last;
  } beat_t;

  typedef struct {
    int n;
    bit rnd;
    bit pat;
    int beats;
    int reads;
  } vec_t;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  // instance 1: latency 1
  logic         start1 = 0;
  logic [5:0]   qbit1 = 0;
  logic         ena1, wea1, valid1, last1, busy1, done1;
  logic         ready1 = 1;
  logic [15:0]  addr1;
  logic [255:0] dout1;
  logic [63:0]  data1;
  logic [17:0]  idx1;

  // instance 2: latency 2
  logic         start2 = 0;
  logic [5:0]   qbit2 = 0;
  logic         ena2, wea2, valid2, last2, busy2, done2;
  logic         ready2 = 1;
  logic [15:0]  addr2;
  logic [255:0] dout2;
  logic [63:0]  data2;
  logic [17:0]  idx2;

  qea_state_reader dut (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_qbit_num(qbit1),
    .o_state_ena(ena1), .o_state_wea(wea1), .o_state_addra(addr1), .i_state_dout(dout1),
    .o_amp_valid(valid1), .i_amp_ready(ready1), .o_amp_data(data1), .o_amp_index(idx1),
    .o_amp_last(last1), .o_busy(busy1), .o_done(done1)
  );

  qea_state_reader #(.RAM_RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_qbit_num(qbit2),
    .o_state_ena(ena2), .o_state_wea(wea2), .o_state_addra(addr2), .i_state_dout(dout2),
    .o_amp_valid(valid2), .i_amp_ready(ready2), .o_amp_data(data2), .o_amp_index(idx2),
    .o_amp_last(last2), .o_busy(busy2), .o_done(done2)
  );

  logic [255:0] mem [0:255];
  logic [255:0] rd1, rd2a, rd2b;
  always @(posedge clk) begin
    if (ena1) rd1 <= mem[addr1[7:0]];
    if (ena2) rd2a <= mem[addr2[7:0]];
    rd2b <= rd2a;
  end
  assign dout1 = rd1;
  assign dout2 = rd2b;

  int checks = 0;
  int errors = 0;
  beat_t q1[$], q2[$];
  beat_t e1, e2;
  bit rnd_mode = 0;
  bit wea_seen = 0;
  int cyc = 0;
  int beats1 = 0, beats2 = 0, done1_cnt = 0, done2_cnt = 0, reads1 = 0, reads2 = 0;
  int first_addr = -1;
  int rd_cyc2 = 0;
  bit pv2 = 0;
  bit stall1 = 0;
  logic [63:0] hold_d;
  logic [17:0] hold_i;
  logic        hold_l;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && valid1 && ready1) beats1++;
    if (rst_n && valid2 && ready2) beats2++;
    if (done1) done1_cnt++;
    if (done2) done2_cnt++;
    if (ena1) begin
      if (reads1 == 0) first_addr = int'(addr1);
      reads1++;
    end
    if (ena2) reads2++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    ready1 = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (wea1 || wea2) wea_seen = 1;
    if (!rst_n) begin
      stall1 = 0;
    end else begin
      if (stall1) begin
        check("hold_valid", 64'(valid1), 64'd1);
        check("hold_data", data1, hold_d);
        check("hold_idx", 64'(idx1), 64'(hold_i));
        check("hold_last", 64'(last1), 64'(hold_l));
      end
      if (valid1 && ready1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_extra got beat idx %0d expected none", idx1);
        end else begin
          e1 = q1.pop_front();
          check("beat_data", data1, e1.d);
          check("beat_idx", 64'(idx1), 64'(e1.idx));
          check("beat_last", 64'(last1), 64'(e1.last));
        end
      end
      stall1 = valid1 && !ready1;
      hold_d = data1; hold_i = idx1; hold_l = last1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ena2) rd_cyc2 = cyc;
      if (valid2 && !pv2) check("rd_to_valid_l2", 64'(cyc - rd_cyc2), 64'd3);
      if (valid2 && ready2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_extra got beat idx %0d expected none", idx2);
        end else begin
          e2 = q2.pop_front();
          check("l2_data", data2, e2.d);
          check("l2_idx", 64'(idx2), 64'(e2.idx));
          check("l2_last", 64'(last2), 64'(e2.last));
        end
      end
      pv2 = valid2;
    end
  end

  task automatic fill(input bit pat);
    for (int w = 0; w < 256; w++) begin
      mem[w] = '0;
      if (pat) for (int j = 0; j < 8; j++) mem[w][j*32 +: 32] = $urandom;
    end
    if (!pat) mem[0] = {64'h40000000_00000000, 192'h0};
  endtask

  task automatic push_exp(input int n, input bit sel);
    int nn, wn, sn;
    beat_t b;
    nn = (n > 18) ? 18 : n;
    wn = (nn > 2) ? (1 << (nn - 2)) : 1;
    sn = (nn >= 2) ? 4 : (1 << nn);
    for (int w = 0; w < wn; w++) begin
      for (int k = 0; k < sn; k++) begin
        b.d = mem[w][(4-k)*64-1 -: 64];
        b.idx = 18'(w*4 + k);
        b.last = (w == wn-1) && (k == sn-1);
        if (sel) q2.push_back(b); else q1.push_back(b);
      end
    end
  endtask

  task automatic wait_done(input bit sel, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel ? done2_cnt : done1_cnt) != 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout got no done expected done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic start_run(input int n);
    beats1 = 0; done1_cnt = 0; reads1 = 0; first_addr = -1;
    @(negedge clk);
    start1 = 1; qbit1 = 6'(n);
    @(negedge clk);
    start1 = 0;
  endtask

  task automatic run_vec(input vec_t v);
    fill(v.pat);
    push_exp(v.n, 0);
    rnd_mode = v.rnd;
    start_run(v.n);
    wait_done(0, 5000, "run");
    rnd_mode = 0;
    check("beats", 64'(beats1), 64'(v.beats));
    check("done_pulses", 64'(done1_cnt), 64'd1);
    check("reads", 64'(reads1), 64'(v.reads));
    check("first_addr", 64'(first_addr), 64'd0);
    check("sb_empty", 64'(q1.size()), 64'd0);
    check("busy_after", 64'(busy1), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8, 1'b0, 1'b0, 256, 64};
    vecs[1] = '{8, 1'b1, 1'b1, 256, 64};
    vecs[2] = '{2, 1'b0, 1'b1, 4, 1};
    vecs[3] = '{1, 1'b1, 1'b1, 2, 1};
    vecs[4] = '{0, 1'b0, 1'b1, 1, 1};

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid1), 64'd0);
    check("rst_ena", 64'(ena1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_idx", 64'(idx1), 64'd0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // start re-pulsed mid-stream must be ignored
    fill(1);
    push_exp(8, 0);
    start_run(8);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (beats1 >= 50) break;
    end
    start1 = 1; qbit1 = 6'd4;
    @(negedge clk);
    start1 = 0;
    wait_done(0, 5000, "restart_ignored");
    check("restart_beats", 64'(beats1), 64'd256);
    check("restart_sb_empty", 64'(q1.size()), 64'd0);

    // reset for one cycle while beat 100 is presented
    fill(1);
    push_exp(8, 0);
    start_run(8);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (valid1 && idx1 == 18'd100) break;
    end
    check("pre_reset_idx", 64'(idx1), 64'd100);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_valid", 64'(valid1), 64'd0);
    check("mid_rst_busy", 64'(busy1), 64'd0);
    check("mid_rst_data", data1, 64'd0);
    check("mid_rst_idx", 64'(idx1), 64'd0);
    check("mid_rst_ena", 64'(ena1), 64'd0);
    check("mid_rst_last", 64'(last1), 64'd0);
    rst_n = 1;
    q1.delete();
    run_vec('{2, 1'b0, 1'b1, 4, 1});

    // latency-2 RAM
    fill(1);
    push_exp(4, 1);
    beats2 = 0; done2_cnt = 0; reads2 = 0;
    @(negedge clk);
    start2 = 1; qbit2 = 6'd4;
    @(negedge clk);
    start2 = 0;
    wait_done(1, 2000, "l2_run");
    check("l2_beats", 64'(beats2), 64'd16);
    check("l2_reads", 64'(reads2), 64'd4);
    check("l2_done", 64'(done2_cnt), 64'd1);
    check("l2_sb_empty", 64'(q2.size()), 64'd0);

    check("wea_zero", 64'(wea_seen), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
